// File: rtl/mem16x10_bram.sv
// ============================================================================
// Module   : mem16x10_bram
// Brief    : 1024 x 16 single-port synchronous RAM, write-first, registered
//            read data, preloaded so that every word holds its own address.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem16x10_bram (
    input  logic        clka,
    input  logic        rsta,
    input  logic [0:0]  wea,
    input  logic [9:0]  addra,
    input  logic [15:0] dina,
    output logic [15:0] douta
);

    localparam int DEPTH = 1024;
    localparam int WIDTH = 16;

    typedef logic [WIDTH-1:0] mem_t [0:DEPTH-1];

    function automatic mem_t identity_image();
        mem_t img;
        for (int i = 0; i < DEPTH; i++) begin
            img[i] = WIDTH'(i);
        end
        return img;
    endfunction

    // Power-up image: a declaration initializer becomes the block-RAM init
    // contents, so reset never touches the array.
    mem_t mem = identity_image();

    always_ff @(posedge clka) begin
        if (wea[0] && !rsta) begin
            mem[addra] <= dina;
        end
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            douta <= '0;
        end else if (wea[0]) begin
            douta <= dina;
        end else begin
            douta <= mem[addra];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem16x10_bram.sv
// ============================================================================
// Module   : tb_mem16x10_bram
// Brief    : Self-checking bench for mem16x10_bram, directed plus random.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem16x10_bram;

    logic        clka;
    logic        rsta;
    logic [0:0]  wea;
    logic [9:0]  addra;
    logic [15:0] dina;
    logic [15:0] douta;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] model [0:1023];
    logic [15:0] expected;

    mem16x10_bram dut (
        .clka  (clka),
        .rsta  (rsta),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .douta (douta)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One access: drive on the falling edge, update the model at the rising
    // edge, compare 1 ns later.
    task automatic access(input string tag, input logic we, input logic [9:0] a,
                          input logic [15:0] d, input logic r);
        @(negedge clka);
        wea   = we;
        addra = a;
        dina  = d;
        rsta  = r;
        @(posedge clka);
        if (r) begin
            expected = 16'h0000;
        end else if (we) begin
            model[a] = d;
            expected = d;
        end else begin
            expected = model[a];
        end
        #1;
        check_eq(tag, douta, expected);
    endtask

    initial begin
        logic [9:0] a;
        logic       we;
        logic [15:0] d;
        logic [9:0] preload_addrs [8];

        for (int i = 0; i < 1024; i++) model[i] = 16'(i);
        preload_addrs = '{10'd1, 10'd2, 10'd3, 10'd23, 10'd63, 10'd1020, 10'd655, 10'd654};

        wea = 1'b0; addra = '0; dina = '0; rsta = 1'b0;
        #1 rsta = 1'b1;
        #1 check_eq("reset_init", douta, 16'h0000);
        access("reset_hold", 1'b0, 10'd7, 16'h0, 1'b1);

        foreach (preload_addrs[i])
            access("preload", 1'b0, preload_addrs[i], 16'h0, 1'b0);

        access("wf_write", 1'b1, 10'd332, 16'd166, 1'b0);
        access("wf_read",  1'b0, 10'd332, 16'h0,   1'b0);

        access("top_write", 1'b1, 10'd1023, 16'hFFFF, 1'b0);
        access("top_read",  1'b0, 10'd1023, 16'h0,    1'b0);
        access("top_nbr",   1'b0, 10'd1022, 16'h0,    1'b0);
        check_eq("top_nbr_const", douta, 16'h03FE);

        access("ovw_write", 1'b1, 10'd1, 16'hFFFF, 1'b0);
        access("ovw_read1", 1'b0, 10'd1, 16'h0,    1'b0);
        access("ovw_read2", 1'b0, 10'd2, 16'h0,    1'b0);
        check_eq("ovw_read2_const", douta, 16'h0002);

        access("rst_pre", 1'b0, 10'd656, 16'h0, 1'b0);
        check_eq("rst_pre_const", douta, 16'h0290);
        #2 rsta = 1'b1;
        #1 check_eq("rst_async", douta, 16'h0000);
        access("rst_wr_blocked", 1'b1, 10'd5, 16'hAAAA, 1'b1);
        access("rst_after",      1'b0, 10'd5, 16'h0,    1'b0);
        check_eq("rst_after_const", douta, 16'h0005);

        access("samp_a", 1'b0, 10'd100, 16'h0, 1'b0);
        @(negedge clka);
        addra = 10'd200;
        dina  = 16'h1234;
        #1 check_eq("samp_mid_addr", douta, 16'd100);
        wea = 1'b1;
        #1 check_eq("samp_mid_we", douta, 16'd100);
        wea = 1'b0;
        @(posedge clka);
        #1 check_eq("samp_next", douta, model[200]);

        for (int n = 0; n < 3000; n++) begin
            a  = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 31)) : 10'($urandom);
            we = ($urandom_range(0, 2) == 0);
            d  = 16'($urandom);
            access("random", we, a, d, ($urandom_range(0, 49) == 0));
        end

        for (int i = 0; i < 1024; i += 37)
            access("sweep", 1'b0, 10'(i), 16'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
